// File: rtl/bc_display_pkg.sv
// Shared types and glyph table for the Bulls-and-Cows 7-segment display path.
package bc_display_pkg;

    typedef logic [5:0] char_t;

    localparam char_t CH_P     = 6'd10;
    localparam char_t CH_S     = 6'd11;
    localparam char_t CH_U     = 6'd12;
    localparam char_t CH_E     = 6'd13;
    localparam char_t CH_L     = 6'd14;
    localparam char_t CH_B     = 6'd15;
    localparam char_t CH_C     = 6'd16;
    localparam char_t CH_G     = 6'd17;
    localparam char_t CH_N     = 6'd18;
    localparam char_t CH_R     = 6'd19;
    localparam char_t CH_BLANK = 6'd20;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; element 20 (blank) is listed first.
    localparam logic [20:0][6:0] GLYPH_TABLE = {
        SEG_BLANK, 7'h2F, 7'h2B, 7'h42, 7'h46, 7'h03, 7'h47, 7'h06, 7'h41, 7'h12, 7'h0C,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/bc_display_scan_seg7_decode.sv
// Combinational character-code to active-low 7-segment glyph decoder.
module seg7_decode
    import bc_display_pkg::*;
(
    input  logic [5:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (code <= CH_BLANK) begin
            seg = GLYPH_TABLE[code[4:0]];
        end
    end

endmodule

// File: rtl/bc_display_scan.sv
// 8-digit common-anode scan driver with per-frame snapshot of the game digit codes.
// Optional blinking is enabled by defining DISPLAY_BLINK_EN (adds blink_mask port).
module bc_display_scan
    import bc_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
`ifdef DISPLAY_BLINK_EN
    ,
    parameter int unsigned BLINK_FRAMES = 64
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] d1,
    input  logic [5:0] d2,
    input  logic [5:0] d3,
    input  logic [5:0] d4,
    input  logic [5:0] d5,
    input  logic [5:0] d6,
    input  logic [5:0] d7,
    input  logic [5:0] d8,
`ifdef DISPLAY_BLINK_EN
    input  logic [7:0] blink_mask,
`endif
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    char_t         shadow [8];
    logic          frame_start;
    logic          slot_tick;
    logic          wrap;
    logic [6:0]    glyph;
    logic          hide;

    assign slot_tick = (prescaler == PW'(REFRESH_DIV - 1));
    assign wrap      = slot_tick && (idx == 3'd7);

    seg7_decode u_decode (
        .code(shadow[idx]),
        .seg (glyph)
    );

`ifdef DISPLAY_BLINK_EN
    localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_count;
    logic          blink_phase;

    // Phase advances on the same edge the frame wraps, so a whole frame shares one phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_count <= '0;
            blink_phase <= 1'b0;
        end else if (wrap) begin
            if (blink_count == BW'(BLINK_FRAMES - 1)) begin
                blink_count <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_count <= blink_count + 1'b1;
            end
        end
    end

    assign hide = blink_phase && blink_mask[3'd7 - idx];
`else
    assign hide = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            prescaler   <= '0;
            idx         <= '0;
            shadow      <= '{default: CH_BLANK};
            frame_start <= 1'b0;
            frame_tick  <= 1'b0;
            an          <= 8'hFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
        end else begin
            if (slot_tick) begin
                prescaler <= '0;
                idx       <= idx + 3'd1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end
            if (wrap) begin
                shadow <= '{d1, d2, d3, d4, d5, d6, d7, d8};
            end
            // frame_start marks idx == 0 freshly entered; frame_tick lines up with its an/seg.
            frame_start <= wrap;
            frame_tick  <= frame_start;
            an          <= ~(8'h80 >> idx);
            seg         <= hide ? SEG_BLANK : glyph;
            dp          <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bc_display_scan.sv
// Self-checking bench for bc_display_scan: cycle model, glyph vector table, corner sequences.
module tb_bc_display_scan;

    localparam int unsigned R  = 4;
    localparam int unsigned BF = 2;
    localparam int unsigned FRAME = 8 * R;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic [5:0] dv [8];
    logic [7:0] mask = 8'h00;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clock = ~clock;

`ifdef DISPLAY_BLINK_EN
    bc_display_scan #(.REFRESH_DIV(R), .BLINK_FRAMES(BF)) dut (
`else
    bc_display_scan #(.REFRESH_DIV(R)) dut (
`endif
        .clock(clock), .reset(rst),
        .d1(dv[0]), .d2(dv[1]), .d3(dv[2]), .d4(dv[3]),
        .d5(dv[4]), .d6(dv[5]), .d7(dv[6]), .d8(dv[7]),
`ifdef DISPLAY_BLINK_EN
        .blink_mask(mask),
`endif
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    function automatic logic [6:0] ref_glyph(input int unsigned c);
        case (c)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;  10: return 7'h0C; 11: return 7'h12;
            12: return 7'h41; 13: return 7'h06; 14: return 7'h47; 15: return 7'h03;
            16: return 7'h46; 17: return 7'h42; 18: return 7'h2B; 19: return 7'h2F;
            default: return 7'h7F;
        endcase
    endfunction

    // Reference model: cycle count since reset decides slot and frame; codes captured per frame.
    int unsigned m_cnt   = 0;
    int unsigned m_wraps = 0;
    int unsigned m_snap [8];
    bit          m_valid = 1'b0;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_ft;

    always @(posedge clock) begin
        if (rst) begin
            m_cnt   = 0;
            m_wraps = 0;
            for (int i = 0; i < 8; i++) m_snap[i] = 20;
            e_an    = 8'hFF;
            e_seg   = 7'h7F;
            e_ft    = 1'b0;
            m_valid = 1'b1;
        end else begin : run
            int unsigned k;
            k     = (m_cnt / R) % 8;
            e_an  = ~(8'h80 >> k);
            e_seg = ref_glyph(m_snap[k]);
            if (((m_wraps / BF) % 2 == 1) && mask[7-k]) begin
`ifdef DISPLAY_BLINK_EN
                e_seg = 7'h7F;
`endif
            end
            e_ft = (m_cnt > 0) && (m_cnt % FRAME == 0);
            if ((m_cnt + 1) % FRAME == 0) begin
                for (int i = 0; i < 8; i++) m_snap[i] = dv[i];
                m_wraps++;
            end
            m_cnt++;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clock);
        if (m_valid) begin
            check("model_an", an, e_an);
            check("model_seg", {1'b0, seg}, {1'b0, e_seg});
            check("model_dp", {7'b0, dp}, 8'h01);
            check("model_frame_tick", {7'b0, frame_tick}, {7'b0, e_ft});
        end
    endtask

    task automatic wait_ft(output int unsigned n);
        n = 0;
        for (int i = 0; i < 20 * FRAME; i++) begin
            step();
            n++;
            if (frame_tick === 1'b1) return;
        end
        checks++;
        errors++;
        $display("FAIL frame_tick_timeout: got none, expected pulse within %0d cycles", 20 * FRAME);
    endtask

    typedef struct packed {
        logic [7:0][5:0] d;
        logic [7:0][6:0] s;
    } vec_t;

    vec_t tbl [3];
    int unsigned n1, n2;

    initial begin
        tbl[0].d = {6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1, 6'd0};
        tbl[0].s = {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
        tbl[1].d = {6'd13, 6'd17, 6'd63, 6'd12, 6'd11, 6'd20, 6'd1, 6'd10};
        tbl[1].s = {7'h06, 7'h42, 7'h7F, 7'h41, 7'h12, 7'h7F, 7'h79, 7'h0C};
        tbl[2].d = {6'd21, 6'd19, 6'd18, 6'd16, 6'd15, 6'd14, 6'd9, 6'd8};
        tbl[2].s = {7'h7F, 7'h2F, 7'h2B, 7'h46, 7'h03, 7'h47, 7'h10, 7'h00};

        for (int i = 0; i < 8; i++) dv[i] = 6'(i);

        // Reset held for five cycles, then the first slot shows a blank digit 0.
        for (int i = 0; i < 5; i++) begin
            step();
            check("reset_an", an, 8'hFF);
            check("reset_seg", {1'b0, seg}, 8'h7F);
            check("reset_ft", {7'b0, frame_tick}, 8'h00);
        end
        rst = 1'b0;
        step();
        check("first_an", an, 8'h7F);
        check("first_seg", {1'b0, seg}, 8'h7F);

        wait_ft(n1);
        wait_ft(n2);
        check("frame_period", 8'(n2), 8'(FRAME));

        // Glyph table: every slot of one full frame.
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 8; i++) dv[i] = tbl[v].d[i];
            wait_ft(n1);
            wait_ft(n1);
            for (int k = 0; k < 8; k++) begin
                if (k > 0) for (int c = 0; c < R; c++) step();
                check($sformatf("tbl%0d_an%0d", v, k), an, ~(8'h80 >> k));
                check($sformatf("tbl%0d_seg%0d", v, k), {1'b0, seg}, {1'b0, tbl[v].s[k]});
            end
        end

        // Mid-frame input change stays hidden until the next wrap.
        for (int i = 0; i < 8; i++) dv[i] = 6'(i);
        dv[0] = 6'd3;
        wait_ft(n1);
        wait_ft(n1);
        check("snap_old_d1", {1'b0, seg}, 8'h30);
        for (int c = 0; c < 4 * R; c++) step();
        check("snap_at_idx4", an, 8'hF7);
        dv[0] = 6'd9;
        dv[7] = 6'd0;
        for (int c = 0; c < 3 * R; c++) step();
        check("snap_d8_held_an", an, 8'hFE);
        check("snap_d8_held_seg", {1'b0, seg}, 8'h78);
        wait_ft(n1);
        check("snap_new_d1", {1'b0, seg}, 8'h10);

        // Reset while idx 5 is displayed, then a blank first frame.
        for (int c = 0; c < 2 * FRAME && an !== 8'hFB; c++) step();
        check("reach_idx5", an, 8'hFB);
        rst = 1'b1;
        step();
        check("midreset_an", an, 8'hFF);
        check("midreset_seg", {1'b0, seg}, 8'h7F);
        rst = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            step();
            check("blank_frame_seg", {1'b0, seg}, 8'h7F);
        end
        step();
        check("after_blank_ft", {7'b0, frame_tick}, 8'h01);

`ifdef DISPLAY_BLINK_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        mask = 8'h80;
        for (int i = 0; i < 8; i++) dv[i] = 6'(i);
        dv[0] = 6'd8;
        for (int c = 0; c < 10 * FRAME; c++) step();
`endif

        // Randomized soak against the model.
        for (int c = 0; c < 3000; c++) begin
            step();
            if ($urandom % 12 == 0) dv[$urandom % 8] = 6'($urandom % 64);
            rst = ($urandom % 600 == 0);
`ifdef DISPLAY_BLINK_EN
            if ($urandom % 50 == 0) mask = 8'($urandom);
`endif
        end
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bc_display_scan.md
Name: bc_display_scan

Overview:
- Consumer of the Bulls-and-Cows game FSM's eight 6-bit digit-code outputs (d1..d8).
- Decodes each code to a 7-segment glyph and time-multiplexes the glyphs onto an 8-digit common-anode display (active-low anodes and segments).
- Captures all eight codes once per scan frame, so a digit never shows a mix of old and new game values within one frame.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot. Must be >= 1. At 100 MHz this gives 1 kHz per digit and 125 Hz per frame.
- BLINK_FRAMES, 64: scan frames per blink half-period. Used only with DISPLAY_BLINK_EN.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- d1..d8  in  6 each  character codes; d1 is the leftmost digit (an[7]), d8 is the rightmost (an[0])
- blink_mask  in  8  bit i blinks digit an[i]; present only with DISPLAY_BLINK_EN
- an  out  8  digit enables, active-low, one-hot-low
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low; always 1 (off)
- frame_tick  out  1  one-cycle pulse on the cycle the new frame's first slot (idx 0) is presented

Behaviour:
- Reset values:
  - an = 8'hFF, seg = 7'h7F, dp = 1, frame_tick = 0
  - prescaler = 0, idx = 0
  - all eight shadow registers = CH_BLANK (20)
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - slot_tick is asserted on the cycle the count equals REFRESH_DIV-1.
  - REFRESH_DIV = 1 gives slot_tick every cycle.
- Digit index:
  - idx is 3 bits and advances on slot_tick, wrapping 7 -> 0.
  - idx k selects shadow[k]: shadow[0] holds d1, shadow[7] holds d8.
  - idx k drives an = ~(8'b1000_0000 >> k).
- Snapshot:
  - On slot_tick with idx == 7, all shadow registers load d1..d8 in the same edge as idx wraps to 0.
  - Input changes at any other time are invisible until the next wrap.
  - The first frame after reset displays blanks.
- Output timing:
  - an and seg are registered and reflect the current idx and shadow.
  - An outputs follow idx starting on the first clock after reset deasserts, so digit 0 (an = 8'h7F, showing blank) is driven from that cycle.
  - After each slot_tick, the new an/seg appear one cycle after idx updates; total latency is 1 clock from the idx change.
  - an and seg change on the same edge. No dead time between digits.
- frame_tick:
  - Registered and aligned with the an/seg update that presents idx 0.
  - Pulses once per 8*REFRESH_DIV cycles.
- Character decode (seg, active-low):
  - 0 = 0x40, 1 = 0x79, 2 = 0x24, 3 = 0x30, 4 = 0x19
  - 5 = 0x12, 6 = 0x02, 7 = 0x78, 8 = 0x00, 9 = 0x10
  - 10 'P' = 0x0C, 11 'S' = 0x12, 12 'U' = 0x41, 13 'E' = 0x06
  - 14 'L' = 0x47, 15 'b' = 0x03, 16 'C' = 0x46, 17 'G' = 0x42
  - 18 'n' = 0x2B, 19 'r' = 0x2F, 20 blank = 0x7F
  - Codes 21..63 decode to blank (0x7F).
- Reset mid-frame: immediately returns to the reset state on the next edge, including blank shadows. No partial frame completes.

Optional Feature:
- Macro: DISPLAY_BLINK_EN.
- With the macro defined:
  - Adds the blink_mask port and a frame counter that toggles blink_phase every BLINK_FRAMES frame_ticks.
  - blink_phase resets to 0 (visible).
  - While blink_phase = 1, a slot whose an bit is set in blink_mask drives seg = 0x7F. Its an is still driven low.
  - blink_mask is sampled live each slot, not snapshotted.
- Without the macro: no blink_mask port, no frame counter, glyphs are always shown.

Decomposition:
- Package bc_display_pkg:
  - char_t = logic [5:0]
  - constants CH_P = 10, CH_S = 11, CH_U = 12, CH_E = 13, CH_L = 14, CH_B = 15, CH_C = 16, CH_G = 17, CH_N = 18, CH_R = 19, CH_BLANK = 20
  - SEG_BLANK = 7'h7F
  - the glyph-table values above
- Sub-module seg7_decode: purely combinational char_t -> seg[6:0]. It is instantiated once on the muxed shadow output, and the registers stay in bc_display_scan.

Test Plan:
1. Reset held 5 cycles with REFRESH_DIV = 4 -> an = FF, seg = 7F, dp = 1, frame_tick = 0 throughout reset. First post-reset cycles show an = 7F, seg = 7F.
2. REFRESH_DIV = 4, d1..d8 = 0..7 -> after the first wrap, an steps 7F, BF, DF, EF, F7, FB, FD, FE, each held 4 cycles. seg steps 40, 79, 24, 30, 19, 12, 02, 78. frame_tick pulses every 32 cycles.
3. d1..d8 = {10, 1, 20, 11, 12, 63, 17, 13} -> seg = 0C, 79, 7F, 12, 41, 7F, 42, 06.
4. Change d1 from 3 to 9 while idx = 4 -> seg stays 0x30 on an = 7F until after the next frame_tick, then shows 0x10.
5. Assert reset while idx = 5 -> next cycle an = FF, seg = 7F. The following frame is blank until the next wrap.
6. DISPLAY_BLINK_EN, BLINK_FRAMES = 2, blink_mask = 80, d1 = 8 -> an[7] slot shows 0x00 for 2 frames and 0x7F for 2 frames, alternating. Other digits are unaffected.
